// File: rtl/cpu5_memarb.sv
// cpu5 memory-port arbiter: shares the one memory port between fetch and load/store, with load/store first.
// Defining CPU5_MEMARB_FAIRNESS_EN adds a starvation guard that forces a fetch grant after STARVE_MAX load/store grants.
module cpu5_memarb #(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic            if_req_i,
  input  logic [AW-1:0]   if_addr_i,
  output logic            if_ack_o,
  output logic [DW-1:0]   if_rdata_o,
  input  logic            ls_req_i,
  input  logic            ls_we_i,
  input  logic [DW/8-1:0] ls_be_i,
  input  logic [AW-1:0]   ls_addr_i,
  input  logic [DW-1:0]   ls_wdata_i,
  output logic            ls_ack_o,
  output logic [DW-1:0]   ls_rdata_o,
  output logic            mem_req_o,
  output logic            mem_we_o,
  output logic [DW/8-1:0] mem_be_o,
  output logic [AW-1:0]   mem_addr_o,
  output logic [DW-1:0]   mem_wdata_o,
  input  logic [DW-1:0]   mem_rdata_i,
  input  logic            mem_ack_i
);

  typedef enum logic [1:0] {IDLE, IF_BUSY, LS_BUSY} state_t;

  state_t            state_q;
  logic              mem_req_q;
  logic              mem_we_q;
  logic [DW/8-1:0]   mem_be_q;
  logic [AW-1:0]     mem_addr_q;
  logic [DW-1:0]     mem_wdata_q;
  logic              grant_ls;
  logic              grant_if;

`ifdef CPU5_MEMARB_FAIRNESS_EN
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  logic [3:0] starve_q;
  logic [3:0] starve_d;

  // Fetch overrides load/store only when it has waited STARVE_MAX grants in a row.
  assign grant_ls = ls_req_i && !(if_req_i && (starve_q == STARVE_LIM));
  assign grant_if = if_req_i && !grant_ls;

  always_comb begin
    starve_d = starve_q;
    if (state_q == IDLE) begin
      if (grant_if) begin
        starve_d = '0;
      end else if (grant_ls) begin
        if (!if_req_i)                  starve_d = '0;
        else if (starve_q != STARVE_LIM) starve_d = starve_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) starve_q <= '0;
    else         starve_q <= starve_d;
  end
`else
  assign grant_ls = ls_req_i;
  assign grant_if = if_req_i && !ls_req_i;
`endif

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_be_q    <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant_ls) begin
            state_q     <= LS_BUSY;
            mem_req_q   <= 1'b1;
            mem_we_q    <= ls_we_i;
            mem_be_q    <= ls_be_i;
            mem_addr_q  <= ls_addr_i;
            mem_wdata_q <= ls_wdata_i;
          end else if (grant_if) begin
            state_q     <= IF_BUSY;
            mem_req_q   <= 1'b1;
            mem_we_q    <= 1'b0;
            mem_be_q    <= '1;
            mem_addr_q  <= if_addr_i;
            mem_wdata_q <= '0;
          end
        end
        IF_BUSY, LS_BUSY: begin
          if (mem_ack_i) begin
            state_q   <= IDLE;
            mem_req_q <= 1'b0;
          end
        end
        default: begin
          state_q   <= IDLE;
          mem_req_q <= 1'b0;
        end
      endcase
    end
  end

  // Acks are combinational from mem_ack; gated by reset so an abandoned transfer never completes.
  assign if_ack_o    = !reset_i && (state_q == IF_BUSY) && mem_ack_i;
  assign ls_ack_o    = !reset_i && (state_q == LS_BUSY) && mem_ack_i;
  assign if_rdata_o  = mem_rdata_i;
  assign ls_rdata_o  = mem_rdata_i;

  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = mem_we_q;
  assign mem_be_o    = mem_be_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;

endmodule

// File: tb/tb_cpu5_memarb.sv
// Directed bench for cpu5_memarb; fairness expectations follow CPU5_MEMARB_FAIRNESS_EN with STARVE_MAX=2.
module tb_cpu5_memarb;
  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_ack;
  logic [DW-1:0] if_rdata;
  logic          ls_req;
  logic          ls_we;
  logic [3:0]    ls_be;
  logic [AW-1:0] ls_addr;
  logic [DW-1:0] ls_wdata;
  logic          ls_ack;
  logic [DW-1:0] ls_rdata;
  logic          mem_req;
  logic          mem_we;
  logic [3:0]    mem_be;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ack;

  int n_total = 0;
  int n_pass  = 0;

  cpu5_memarb #(.AW(AW), .DW(DW), .STARVE_MAX(2)) dut (
    .clk_i(clk), .reset_i(reset),
    .if_req_i(if_req), .if_addr_i(if_addr), .if_ack_o(if_ack), .if_rdata_o(if_rdata),
    .ls_req_i(ls_req), .ls_we_i(ls_we), .ls_be_i(ls_be), .ls_addr_i(ls_addr),
    .ls_wdata_i(ls_wdata), .ls_ack_o(ls_ack), .ls_rdata_o(ls_rdata),
    .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_be_o(mem_be), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata), .mem_ack_i(mem_ack)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; if_req = 0; if_addr = '0; ls_req = 0; ls_we = 0; ls_be = '0;
    ls_addr = '0; ls_wdata = '0; mem_rdata = '0; mem_ack = 0;
    step(); step();
    n_total++;
    if ({mem_req, mem_we, mem_be, mem_addr, mem_wdata, if_ack, ls_ack} !== '0) begin
      $display("FAIL reset_outputs: got req=%b we=%b be=%h addr=%h wdata=%h ifack=%b lsack=%b, want all 0",
               mem_req, mem_we, mem_be, mem_addr, mem_wdata, if_ack, ls_ack);
    end else n_pass++;
    reset = 1'b0;
    step();
    mem_ack = 1'b1; mem_rdata = 32'hDEAD_0001;
    @(negedge clk);
    n_total++;
    if ({if_ack, ls_ack} !== 2'b00) $display("FAIL reset_stale_ack: got if_ack=%b ls_ack=%b, want 0 0", if_ack, ls_ack);
    else n_pass++;
    step();
    mem_ack = 1'b0;
    n_total++;
    if (mem_req !== 1'b0) $display("FAIL reset_stale_req: got mem_req=%b, want 0", mem_req);
    else n_pass++;
  endtask

  task automatic test_single_fetch();
    if_req = 1'b1; if_addr = 32'h100;
    step();
    n_total++;
    if ({mem_req, mem_we, mem_be, mem_addr} !== {1'b1, 1'b0, 4'hF, 32'h100})
      $display("FAIL fetch_issue: got req=%b we=%b be=%h addr=%h, want 1 0 f 00000100", mem_req, mem_we, mem_be, mem_addr);
    else n_pass++;
    mem_ack = 1'b1; mem_rdata = 32'h00A0_0093;
    @(negedge clk);
    n_total++;
    if ({if_ack, ls_ack, if_rdata} !== {1'b1, 1'b0, 32'h00A0_0093})
      $display("FAIL fetch_ack: got if_ack=%b ls_ack=%b rdata=%h, want 1 0 00a00093", if_ack, ls_ack, if_rdata);
    else n_pass++;
    step();
    if_req = 1'b0; mem_ack = 1'b0;
    n_total++;
    if (mem_req !== 1'b0) $display("FAIL fetch_release: got mem_req=%b, want 0", mem_req);
    else n_pass++;
    step();
  endtask

  task automatic test_store_waits();
    ls_req = 1'b1; ls_we = 1'b1; ls_be = 4'b0011; ls_addr = 32'h2004; ls_wdata = 32'hBEEF;
    step();
    for (int i = 0; i < 4; i++) begin
      if (i == 3) begin mem_ack = 1'b1; mem_rdata = 32'h1234_5678; end
      @(negedge clk);
      n_total++;
      if ({mem_req, mem_we, mem_be, mem_addr, mem_wdata} !== {1'b1, 1'b1, 4'b0011, 32'h2004, 32'hBEEF})
        $display("FAIL store_hold[%0d]: got req=%b we=%b be=%h addr=%h wdata=%h, want 1 1 3 00002004 0000beef",
                 i, mem_req, mem_we, mem_be, mem_addr, mem_wdata);
      else n_pass++;
      n_total++;
      if ({ls_ack, if_ack} !== {(i == 3), 1'b0})
        $display("FAIL store_ack[%0d]: got ls_ack=%b if_ack=%b, want %b 0", i, ls_ack, if_ack, (i == 3));
      else n_pass++;
      step();
    end
    ls_req = 1'b0; ls_we = 1'b0; mem_ack = 1'b0;
    step();
  endtask

  task automatic test_collision();
    if_req = 1'b1; if_addr = 32'h140;
    ls_req = 1'b1; ls_we = 1'b0; ls_be = 4'hF; ls_addr = 32'h3000; ls_wdata = '0;
    step();
    n_total++;
    if ({mem_req, mem_addr} !== {1'b1, 32'h3000})
      $display("FAIL collide_first: got req=%b addr=%h, want 1 00003000", mem_req, mem_addr);
    else n_pass++;
    mem_ack = 1'b1; mem_rdata = 32'hCAFE_F00D;
    @(negedge clk);
    n_total++;
    if ({ls_ack, if_ack, ls_rdata} !== {1'b1, 1'b0, 32'hCAFE_F00D})
      $display("FAIL collide_lsack: got ls_ack=%b if_ack=%b rdata=%h, want 1 0 cafef00d", ls_ack, if_ack, ls_rdata);
    else n_pass++;
    step();
    ls_req = 1'b0; mem_ack = 1'b0;
    n_total++;
    if (mem_req !== 1'b0) $display("FAIL collide_idle: got mem_req=%b, want 0", mem_req);
    else n_pass++;
    step();
    n_total++;
    if ({mem_req, mem_we, mem_be, mem_addr} !== {1'b1, 1'b0, 4'hF, 32'h140})
      $display("FAIL collide_second: got req=%b we=%b be=%h addr=%h, want 1 0 f 00000140", mem_req, mem_we, mem_be, mem_addr);
    else n_pass++;
    mem_ack = 1'b1;
    @(negedge clk);
    n_total++;
    if ({if_ack, ls_ack} !== 2'b10) $display("FAIL collide_ifack: got if_ack=%b ls_ack=%b, want 1 0", if_ack, ls_ack);
    else n_pass++;
    step();
    if_req = 1'b0; mem_ack = 1'b0;
    step();
  endtask

  task automatic test_fairness();
    logic [5:0] exp_is_if;
`ifdef CPU5_MEMARB_FAIRNESS_EN
    exp_is_if = 6'b100100;   // bit i = grant i; LS, LS, IF, LS, LS, IF
`else
    exp_is_if = 6'b000000;
`endif
    if_req = 1'b1; if_addr = 32'h500;
    ls_req = 1'b1; ls_we = 1'b1; ls_be = 4'hF; ls_addr = 32'h6000; ls_wdata = 32'h55;
    step();
    for (int i = 0; i < 6; i++) begin
      n_total++;
      if ({mem_req, mem_addr} !== {1'b1, exp_is_if[i] ? 32'h500 : 32'h6000})
        $display("FAIL fair_grant[%0d]: got req=%b addr=%h, want 1 %h", i, mem_req, mem_addr,
                 exp_is_if[i] ? 32'h500 : 32'h6000);
      else n_pass++;
      mem_ack = 1'b1;
      @(negedge clk);
      n_total++;
      if ({if_ack, ls_ack} !== {exp_is_if[i], ~exp_is_if[i]})
        $display("FAIL fair_ack[%0d]: got if_ack=%b ls_ack=%b, want %b %b", i, if_ack, ls_ack, exp_is_if[i], ~exp_is_if[i]);
      else n_pass++;
      step();
      mem_ack = 1'b0;
      step();
    end
    // Grant 7 is already issued; release requesters and complete it.
    if_req = 1'b0; ls_req = 1'b0; ls_we = 1'b0;
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    step();
  endtask

  task automatic test_reset_mid();
    ls_req = 1'b1; ls_we = 1'b1; ls_be = 4'hF; ls_addr = 32'h7000; ls_wdata = 32'h77;
    step();
    n_total++;
    if (mem_req !== 1'b1) $display("FAIL midrst_busy: got mem_req=%b, want 1", mem_req);
    else n_pass++;
    reset = 1'b1; ls_req = 1'b0;
    step();
    reset = 1'b0;
    n_total++;
    if (mem_req !== 1'b0) $display("FAIL midrst_drop: got mem_req=%b, want 0", mem_req);
    else n_pass++;
    step();
    mem_ack = 1'b1;
    @(negedge clk);
    n_total++;
    if ({ls_ack, if_ack} !== 2'b00) $display("FAIL midrst_lateack: got ls_ack=%b if_ack=%b, want 0 0", ls_ack, if_ack);
    else n_pass++;
    step();
    mem_ack = 1'b0; if_req = 1'b1; if_addr = 32'h300;
    n_total++;
    if (mem_req !== 1'b0) $display("FAIL midrst_noreissue: got mem_req=%b, want 0", mem_req);
    else n_pass++;
    step();
    n_total++;
    if ({mem_req, mem_we, mem_addr} !== {1'b1, 1'b0, 32'h300})
      $display("FAIL midrst_fetch: got req=%b we=%b addr=%h, want 1 0 00000300", mem_req, mem_we, mem_addr);
    else n_pass++;
    mem_ack = 1'b1; mem_rdata = 32'h0000_0013;
    @(negedge clk);
    n_total++;
    if ({if_ack, if_rdata} !== {1'b1, 32'h13}) $display("FAIL midrst_fetchack: got if_ack=%b rdata=%h, want 1 00000013", if_ack, if_rdata);
    else n_pass++;
    step();
    if_req = 1'b0; mem_ack = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_single_fetch();
    test_store_waits();
    test_collision();
    test_fairness();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/cpu5_memarb.md
# cpu5_memarb

Arbiter that shares the single cpu5 memory port between the instruction-fetch requester and the load/store requester. It registers the winning request onto the memory bus, holds it until the memory acknowledges, then routes the acknowledge and read data back to the winner. Load/store has fixed priority over fetch by default. A compile-time option adds a starvation guard for fetch. The block sits between the cpu5 datapath (fetch and load/store paths) and the unified instruction/data memory.

## Interface
- `AW`, 32: address width.
- `DW`, 32: data width.
- `STARVE_MAX`, 4: consecutive load/store grants with fetch waiting before fetch is forced. Used only with the fairness macro. Range 1–15.

- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high reset.
- `if_req` in 1: fetch request. Held with `if_addr` until `if_ack`.
- `if_addr` in AW: fetch address.
- `if_ack` out 1: one-cycle completion pulse to fetch.
- `if_rdata` out DW: fetch read data. Valid only with `if_ack`.
- `ls_req` in 1: load/store request. Held with its payload until `ls_ack`.
- `ls_we` in 1: 1 means store.
- `ls_be` in DW/8: byte enables.
- `ls_addr` in AW: load/store address.
- `ls_wdata` in DW: store data.
- `ls_ack` out 1: one-cycle completion pulse to load/store.
- `ls_rdata` out DW: load data. Valid only with `ls_ack`.
- `mem_req` out 1: memory request. Held until `mem_ack`.
- `mem_we` out 1: memory write enable.
- `mem_be` out DW/8: memory byte enables.
- `mem_addr` out AW: memory address.
- `mem_wdata` out DW: memory write data.
- `mem_rdata` in DW: memory read data. Valid with `mem_ack`.
- `mem_ack` in 1: one-cycle completion from memory.

## Operation
FSM states: IDLE, IF_BUSY, LS_BUSY.

- **IDLE**
  - No request pending: stay in IDLE.
  - `ls_req` (with or without `if_req`): go to LS_BUSY. Latch `ls_we`/`ls_be`/`ls_addr`/`ls_wdata` into the `mem_*` registers and set `mem_req` to 1.
  - `if_req` only: go to IF_BUSY. Latch `mem_addr=if_addr`, `mem_we=0`, `mem_be` all ones, `mem_wdata=0`, and set `mem_req` to 1.
  - `mem_ack` is ignored in IDLE (stale acks after reset are discarded).
- **IF_BUSY / LS_BUSY**
  - Hold all `mem_*` outputs stable and ignore request inputs.
  - On `mem_ack`: pulse `if_ack` or `ls_ack` combinationally in the same cycle, clear `mem_req` at the clock edge, and return to IDLE.
  - The non-granted ack stays 0.
- Read data: `if_rdata` and `ls_rdata` are both wired to `mem_rdata`. Consumers qualify them with their own ack.
- Requesters: a requester that still has `if_req`/`ls_req` high in the cycle after its ack is treated as issuing a new request.
- `mem_ack` arrives no earlier than the first cycle in which `mem_req` is high.

## Timing
- Reset values: state IDLE; `mem_req`, `mem_we`, `if_ack`, `ls_ack` = 0; `mem_be`, `mem_addr`, `mem_wdata` = 0; starvation counter = 0.
- Request latency: request sampled in IDLE at edge N, `mem_req` high from cycle N+1.
- Ack latency: zero cycles from `mem_ack` to the requester ack (combinational).
- Throughput: minimum 2 cycles per transaction (1 idle/arbitration cycle + 1 memory cycle with zero-wait memory). Each memory wait state adds one cycle.
- Reset mid-transaction:
  - Abandon the transaction and drop `mem_req` the next cycle.
  - No requester ack is produced for the abandoned transaction.
  - A late `mem_ack` arriving in IDLE is ignored.
- Simultaneous `mem_ack` and new requests: the new requests are arbitrated in the following IDLE cycle, not in the ack cycle.

## Configuration
- `CPU5_MEMARB_FAIRNESS_EN` defined:
  - A 4-bit counter increments on each load/store grant made while `if_req` is high. It saturates at `STARVE_MAX`.
  - The counter clears on a fetch grant, or on a load/store grant made with `if_req` low.
  - When the counter equals `STARVE_MAX` and both requests are pending in IDLE, fetch is granted.
- `CPU5_MEMARB_FAIRNESS_EN` undefined: no counter is built, and load/store priority is strict (fetch can starve indefinitely).

## Test plan
- **Reset:** assert `reset` 2 cycles.
  - All outputs 0, state IDLE.
  - Pulse `mem_ack` in IDLE → no `if_ack`/`ls_ack`.
- **Single fetch:** `if_req=1`, `if_addr=0x100`, zero-wait memory returning `0x00A00093`.
  - `mem_req` rises 1 cycle later with `mem_addr=0x100`, `mem_we=0`, `mem_be=4'hF`.
  - `if_ack` pulses with `if_rdata=0x00A00093`.
- **Store with waits:** `ls_req`, `ls_we=1`, `ls_be=4'b0011`, `ls_addr=0x2004`, `ls_wdata=0xBEEF`, memory waits 3 cycles.
  - `mem_*` outputs stable for 4 cycles.
  - `ls_ack` coincides with `mem_ack`.
  - `if_ack` stays 0.
- **Collision:** `if_req` and `ls_req` rise in the same cycle.
  - Load/store is granted first.
  - Fetch is granted in the IDLE cycle after `ls_ack`.
- **Fairness (`STARVE_MAX=2`):** hold `if_req` and `ls_req` continuously.
  - Macro on: grant order LS, LS, IF, LS, LS, IF.
  - Macro off: LS only.
- **Reset mid-operation:** assert `reset` while in LS_BUSY, then pulse `mem_ack` one cycle after reset releases.
  - `mem_req` is 0 the next cycle.
  - No `ls_ack`.
  - The following `if_req` is serviced normally.
